// File: rtl/led595_scan_ctrl.sv
// led595_scan_ctrl
//   Scan scheduler for a multiplexed 7-segment display driven through two
//   chained 74hc595 shift registers. The first byte shifted out selects a digit
//   and the second byte carries its segments. Every refresh slot one 16-bit
//   {select, segment} word goes out MSB first and is latched, then the scan
//   moves on to the next digit.
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   disp_data     segment bytes, digit d at [8d+7:8d]
//   disp_load     single-cycle strobe; captures disp_data/blank_mask into the
//                 pending buffer. There is no back-pressure: a strobe is
//                 always accepted in the cycle it is high, in any state.
//   blank_mask    bit d forces digit d to the blank byte
//   led595_dout   595 serial data
//   led595_clk    595 shift clock (595 samples on its rising edge)
//   led595_latch  595 storage clock
//   busy          high while a word is being loaded, shifted or latched
//   frame_done    one-cycle pulse as the last digit's latch phase ends
//   dbg_state     current scan FSM state (IDLE=0, LOAD=1, SHIFT=2, LATCH=3)

module led595_scan_ctrl #(
  parameter int DIGITS      = 4,
  parameter int CLK_DIV     = 4,
  parameter int REFRESH_CNT = 50000,
  parameter int SEG_ACT_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIGITS*8-1:0]   disp_data,
  input  logic                  disp_load,
  input  logic [DIGITS-1:0]     blank_mask,
  output logic                  led595_dout,
  output logic                  led595_clk,
  output logic                  led595_latch,
  output logic                  busy,
  output logic                  frame_done,
  output logic [1:0]            dbg_state
);

  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int RCW  = $clog2(REFRESH_CNT);
  localparam logic [7:0] BLANK = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_LATCH = 2'd3
  } state_t;

  state_t               state, state_n;
  logic [RCW-1:0]       refresh_cnt;
  logic                 tick_pend;
  logic [IDXW-1:0]      idx;
  logic [DIGITS*8-1:0]  pend_data, act_data, src_data;
  logic [DIGITS-1:0]    pend_mask, act_mask, src_mask;
  logic [DIVW-1:0]      div_cnt;
  logic                 half_hi;
  logic [3:0]           bit_cnt;
  logic [15:0]          shift_sr;
  logic [15:0]          word;
  logic                 tick, div_last, idx_last, shift_done;

  assign dbg_state  = state;
  assign tick       = (refresh_cnt == RCW'(REFRESH_CNT - 1));
  assign div_last   = (div_cnt == DIVW'(CLK_DIV - 1));
  assign idx_last   = (idx == IDXW'(DIGITS - 1));
  assign shift_done = half_hi && div_last && (bit_cnt == 4'd15);

  // At the start of a frame the word must come from the buffer being copied
  // into active this very cycle, including a disp_load arriving right now.
  always_comb begin
    src_data = act_data;
    src_mask = act_mask;
    if (idx == '0) begin
      src_data = disp_load ? disp_data  : pend_data;
      src_mask = disp_load ? blank_mask : pend_mask;
    end
    word = {8'd1 << idx, src_mask[idx] ? BLANK : src_data[{idx, 3'b000} +: 8]};
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (tick || tick_pend) state_n = S_LOAD;
      S_LOAD:  state_n = S_SHIFT;
      S_SHIFT: if (shift_done) state_n = S_LATCH;
      S_LATCH: if (div_last) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt  <= '0;
      tick_pend    <= 1'b0;
      idx          <= '0;
      pend_data    <= '0;
      pend_mask    <= '0;
      act_data     <= '0;
      act_mask     <= '0;
      div_cnt      <= '0;
      half_hi      <= 1'b0;
      bit_cnt      <= '0;
      shift_sr     <= '0;
      led595_dout  <= 1'b0;
      led595_clk   <= 1'b0;
      led595_latch <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      refresh_cnt <= tick ? '0 : refresh_cnt + 1'b1;

      // One-deep tick memory: IDLE always consumes it, ticks seen while a
      // word is in flight collapse into a single pending request.
      if (state == S_IDLE)  tick_pend <= 1'b0;
      else if (tick)        tick_pend <= 1'b1;

      if (disp_load) begin
        pend_data <= disp_data;
        pend_mask <= blank_mask;
      end

      // Registered outputs are derived from the next state so they line up
      // with the state register cycle for cycle.
      busy         <= (state_n != S_IDLE);
      led595_latch <= (state_n == S_LATCH);
      frame_done   <= (state == S_LATCH) && div_last && idx_last;

      case (state)
        S_IDLE: begin
          div_cnt     <= '0;
          led595_clk  <= 1'b0;
          led595_dout <= 1'b0;
        end
        S_LOAD: begin
          if (idx == '0) begin
            act_data <= src_data;
            act_mask <= src_mask;
          end
          shift_sr    <= {word[14:0], 1'b0};
          led595_dout <= word[15];
          led595_clk  <= 1'b0;
          div_cnt     <= '0;
          half_hi     <= 1'b0;
          bit_cnt     <= '0;
        end
        S_SHIFT: begin
          if (div_last) begin
            div_cnt    <= '0;
            half_hi    <= ~half_hi;
            led595_clk <= ~half_hi;
            // End of a high half: next bit appears together with the falling
            // shift clock, so dout is stable across every rising edge.
            if (half_hi) begin
              bit_cnt     <= bit_cnt + 1'b1;
              shift_sr    <= {shift_sr[14:0], 1'b0};
              led595_dout <= shift_done ? 1'b0 : shift_sr[15];
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_LATCH: begin
          led595_clk  <= 1'b0;
          led595_dout <= 1'b0;
          if (div_last) begin
            div_cnt <= '0;
            idx     <= idx_last ? '0 : idx + 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_led595_scan_ctrl.sv
module tb_led595_scan_ctrl;

  localparam int DIGITS   = 4;
  localparam int CLK_DIV  = 2;
  localparam int R_MAIN   = 100;
  localparam int R_FAST   = 40;
  localparam int WORD_CYC = 1 + 33 * CLK_DIV;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] disp_data  = '0;
  logic        disp_load  = 1'b0;
  logic [3:0]  blank_mask = '0;

  logic       m_dout, m_sclk, m_latch, m_busy, m_fd;
  logic [1:0] m_dbg;
  logic       f_dout, f_sclk, f_latch, f_busy, f_fd;
  logic [1:0] f_dbg;

  led595_scan_ctrl #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .REFRESH_CNT(R_MAIN), .SEG_ACT_LOW(1)) u_dut (
    .clk(clk), .rst(rst), .disp_data(disp_data), .disp_load(disp_load), .blank_mask(blank_mask),
    .led595_dout(m_dout), .led595_clk(m_sclk), .led595_latch(m_latch), .busy(m_busy),
    .frame_done(m_fd), .dbg_state(m_dbg)
  );

  led595_scan_ctrl #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .REFRESH_CNT(R_FAST), .SEG_ACT_LOW(1)) u_fast (
    .clk(clk), .rst(rst), .disp_data(disp_data), .disp_load(disp_load), .blank_mask(blank_mask),
    .led595_dout(f_dout), .led595_clk(f_sclk), .led595_latch(f_latch), .busy(f_busy),
    .frame_done(f_fd), .dbg_state(f_dbg)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input int act, input int exp);
    total++;
    bad++;
    $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model (slot arithmetic) ----------------
  // Main instance: REFRESH_CNT exceeds the word length, so every tick starts
  // a word. Cycle c after reset is a LOAD when c is a non-zero multiple of
  // R_MAIN; the n-th word of the run shows digit n mod DIGITS.
  int          m_cyc = 0;
  int          m_n   = 0;
  logic [31:0] m_pend = '0, m_act = '0;
  logic [3:0]  m_pmask = '0, m_amask = '0;
  logic [15:0] exp_q[$];
  logic [15:0] obs_log[$];

  function automatic logic [15:0] model_word(input int d, input logic [31:0] data, input logic [3:0] mask);
    logic [7:0] sel;
    logic [7:0] seg;
    sel = 8'(1 << d);
    seg = mask[d] ? 8'hFF : data[8*d +: 8];
    return {sel, seg};
  endfunction

  // monitor state
  logic        prev_busy = 0, prev_sclk = 0, prev_dout = 0, prev_latch = 0;
  int          busy_len = 0, latch_len = 0, bit_n = 0;
  logic [15:0] obs_w = '0;
  logic        f_prev_busy = 0;
  int          f_busy_len = 0, f_idle_len = 0;
  bit          f_first = 1'b1;

  always @(negedge clk) begin
    bit          is_load;
    bit          fd_exp;
    logic [15:0] e;
    int          d;
    is_load = (m_cyc % R_MAIN == 0) && (m_cyc > 0);
    fd_exp  = 1'b0;

    // ---- main instance: timing and serial decode ----
    if ((m_busy && !prev_busy) || is_load)
      chk("load_timing", {31'd0, m_busy && !prev_busy}, {31'd0, is_load});
    if (!m_busy && prev_busy) begin
      chk("busy_len", busy_len, WORD_CYC);
      busy_len = 0;
    end
    if (m_busy) busy_len++;
    if (m_sclk && !prev_sclk) begin
      chk("dout_stable", {31'd0, m_dout}, {31'd0, prev_dout});
      obs_w = {obs_w[14:0], m_dout};
      bit_n++;
    end
    if (m_latch) begin
      latch_len++;
      chk("latch_lines", {30'd0, m_sclk, m_dout}, 32'd0);
    end
    if (!m_latch && prev_latch) begin
      chk("latch_len", latch_len, CLK_DIV);
      chk("bit_count", bit_n, 16);
      obs_log.push_back(obs_w);
      if (exp_q.size() == 0) fail("unexpected_word", obs_w, 0);
      else begin
        e = exp_q.pop_front();
        chk("word", {16'd0, obs_w}, {16'd0, e});
        fd_exp = (e[15:8] == 8'h08);
      end
      latch_len = 0;
      bit_n     = 0;
      obs_w     = '0;
    end
    if (m_fd || fd_exp) chk("frame_done", {31'd0, m_fd}, {31'd0, fd_exp});

    // ---- fast instance: ticks outpace words, must run back to back ----
    if (f_busy && !f_prev_busy) begin
      if (f_first) chk("fast_first_load", m_cyc, R_FAST);
      else         chk("fast_idle_gap", f_idle_len, 1);
      f_first    = 1'b0;
      f_idle_len = 0;
    end
    if (!f_busy && f_prev_busy) begin
      chk("fast_busy_len", f_busy_len, WORD_CYC);
      f_busy_len = 0;
    end
    if (f_busy) f_busy_len++;
    else        f_idle_len++;

    prev_busy   = m_busy;
    prev_sclk   = m_sclk;
    prev_dout   = m_dout;
    prev_latch  = m_latch;
    f_prev_busy = f_busy;

    // ---- model advance for the coming clock edge ----
    if (rst) begin
      m_cyc = 0; m_n = 0;
      m_pend = '0; m_act = '0; m_pmask = '0; m_amask = '0;
      exp_q.delete();
      prev_busy = 0; prev_sclk = 0; prev_dout = 0; prev_latch = 0;
      busy_len = 0; latch_len = 0; bit_n = 0; obs_w = '0;
      f_prev_busy = 0; f_busy_len = 0; f_idle_len = 0; f_first = 1'b1;
    end else begin
      if (is_load) begin
        d = m_n % DIGITS;
        if (d == 0) begin
          m_act   = disp_load ? disp_data  : m_pend;
          m_amask = disp_load ? blank_mask : m_pmask;
        end
        exp_q.push_back(model_word(d, m_act, m_amask));
        m_n++;
      end
      if (disp_load) begin
        m_pend  = disp_data;
        m_pmask = blank_mask;
      end
      m_cyc++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_and_load(input logic [31:0] data, input logic [3:0] mask);
    rst = 1'b1;
    step(1);
    rst        = 1'b0;
    disp_data  = data;
    blank_mask = mask;
    disp_load  = 1'b1;
    obs_log.delete();
    step(1);
    disp_load  = 1'b0;
  endtask

  task automatic wait_words(input int n, input int budget);
    int k;
    k = 0;
    while (obs_log.size() < n && k < budget) begin
      step(1);
      k++;
    end
    if (obs_log.size() < n) fail("wait_words_timeout", obs_log.size(), n);
  endtask

  task automatic wait_cyc(input int c);
    int k;
    k = 0;
    while (m_cyc != c && k < 3000) begin
      step(1);
      k++;
    end
    if (m_cyc != c) fail("wait_cyc_timeout", m_cyc, c);
  endtask

  task automatic chk_log(input string name, input int i, input logic [15:0] exp);
    if (obs_log.size() > i) chk(name, {16'd0, obs_log[i]}, {16'd0, exp});
    else fail(name, obs_log.size(), i + 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] data;
    logic [3:0]  mask;
    logic [63:0] exp_w;   // word k at [16k+15:16k]
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{data: 32'h3F06_5B4F, mask: 4'b0000, exp_w: {16'h083F, 16'h0406, 16'h025B, 16'h014F}};
    vecs[1] = '{data: 32'h3F06_5B4F, mask: 4'b0010, exp_w: {16'h083F, 16'h0406, 16'h02FF, 16'h014F}};
    vecs[2] = '{data: 32'h0000_0000, mask: 4'b1001, exp_w: {16'h08FF, 16'h0400, 16'h0200, 16'h01FF}};
    vecs[3] = '{data: 32'hA5C3_7E81, mask: 4'b1111, exp_w: {16'h08FF, 16'h04FF, 16'h02FF, 16'h01FF}};
    vecs[4] = '{data: 32'h1234_5678, mask: 4'b0100, exp_w: {16'h0812, 16'h04FF, 16'h0256, 16'h0178}};

    // reset state
    rst = 1'b1;
    step(2);
    @(negedge clk);
    chk("reset_outputs", {27'd0, m_dout, m_sclk, m_latch, m_busy, m_fd}, 32'd0);
    chk("reset_state", {30'd0, m_dbg}, 32'd0);
    chk("reset_fast_outputs", {27'd0, f_dout, f_sclk, f_latch, f_busy, f_fd}, 32'd0);
    step(1);

    // table: one frame per vector, four words in scan order
    for (int v = 0; v < 5; v++) begin
      reset_and_load(vecs[v].data, vecs[v].mask);
      wait_words(4, 600);
      for (int k = 0; k < 4; k++)
        chk_log($sformatf("vec%0d_word%0d", v, k), k, vecs[v].exp_w[16*k +: 16]);
    end

    // new data while digit 2 is shifting; then a load in the digit-0 LOAD cycle
    reset_and_load(32'h3F06_5B4F, 4'b0000);
    wait_cyc(305);
    disp_data = 32'h1122_3344;
    disp_load = 1'b1;
    step(1);
    disp_load = 1'b0;
    wait_cyc(900);
    disp_data = 32'hDEAD_BEEF;
    disp_load = 1'b1;
    step(1);
    disp_load = 1'b0;
    wait_words(9, 300);
    chk_log("tear_d2_old", 2, 16'h0406);
    chk_log("tear_d3_old", 3, 16'h083F);
    chk_log("tear_d0_new", 4, 16'h0144);
    chk_log("tear_d1_new", 5, 16'h0233);
    chk_log("tear_d3_new", 7, 16'h0811);
    chk_log("same_cycle_load", 8, 16'h01EF);

    // reset in the middle of a shift
    wait_cyc(1010);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    @(negedge clk);
    chk("midshift_rst_outputs", {27'd0, m_dout, m_sclk, m_latch, m_busy, m_fd}, 32'd0);
    chk("midshift_rst_state", {30'd0, m_dbg}, 32'd0);
    obs_log.delete();
    wait_words(1, 300);
    chk_log("after_rst_word", 0, 16'h0100);

    // randomized loads against the model, with one reset in the middle
    reset_and_load($urandom, 4'($urandom_range(0, 15)));
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) rst = 1'b1;
      else begin
        rst        = 1'b0;
        disp_data  = $urandom;
        blank_mask = 4'($urandom_range(0, 15));
        disp_load  = ($urandom_range(0, 39) == 0);
      end
      step(1);
    end
    rst       = 1'b0;
    disp_load = 1'b0;
    step(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
